score_digit_ctrl: RTL and testbench
===================================

# score_digit_ctrl

- Sequences the shared single-glyph number renderer so that one instance draws a 3-digit decimal readout of an 8-bit value.
- Sits between the 640x480 VGA timing generator and the glyph renderer:
  - takes the current pixel position,
  - picks the digit cell it falls in,
  - feeds the renderer a digit and glyph-local coordinates,
  - returns the gated, pipelined pixel-enable.
- The displayed value is converted to BCD sequentially once per frame, at the frame strobe, so the readout never changes mid-frame.

## Interface

Parameters:
- ORIGIN_X, default 10'd280: x of the left edge of cell 0 (most significant digit).
- ORIGIN_Y, default 9'd220: y of the top edge of all cells.
- CELL_W, default 16: cell width in pixels; integer ≥ 1.
- CELL_H, default 24: cell height in pixels; integer ≥ 1.
- BLANK_LZ, default 1: 1 = blank leading zeros; the ones digit is never blanked.

Ports:
- clk, input, 1: pixel-domain clock.
- reset, input, 1: synchronous, active-high reset.
- i_value, input, 8: value to display, sampled only on i_frame_stb.
- i_frame_stb, input, 1: one-cycle pulse at end of the active frame (timing generator's animate strobe).
- i_x, input, 10: current pixel x.
- i_y, input, 9: current pixel y.
- i_glyph_px, input, 1: renderer pixel output (combinational from o_num/o_gx/o_gy).
- o_num, output, 4: BCD digit to the renderer.
- o_gx, output, 10: glyph-local x.
- o_gy, output, 9: glyph-local y.
- o_cell_active, output, 1: current pixel is inside a non-blanked cell.
- o_draw, output, 1: final pixel-enable.
- o_busy, output, 1: BCD conversion in progress.

## Operation

Conversion FSM, states IDLE, CONV, COMMIT:
- IDLE:
  - On i_frame_stb, latch i_value into an 8-bit shift register and clear a 12-bit BCD accumulator and a 3-bit counter.
  - Go to CONV.
- CONV, one double-dabble iteration per clk:
  - Add 3 to each BCD nibble ≥ 5.
  - Shift {bcd, bin} left by 1.
  - After the 8th iteration (counter = 7), go to COMMIT.
- COMMIT:
  - Copy the accumulator into the display registers d2 (hundreds), d1 (tens), d0 (ones).
  - Return to IDLE.
- o_busy = 1 in CONV and COMMIT.
- i_frame_stb outside IDLE is ignored; no queueing.
- Display registers change only in COMMIT.

Cell mapping (pipeline stage 1, registered every clk):
- Cell k (k = 0..2) covers:
  - x in [ORIGIN_X + k·CELL_W, ORIGIN_X + (k+1)·CELL_W − 1];
  - y in [ORIGIN_Y, ORIGIN_Y + CELL_H − 1].
- In cell k:
  - o_num = d2, d1, d0 for k = 0, 1, 2;
  - o_gx = i_x − ORIGIN_X − k·CELL_W;
  - o_gy = i_y − ORIGIN_Y.
- Cell selection uses comparators only; no divider.
- Leading-zero blanking (BLANK_LZ = 1):
  - cell 0 is blanked when d2 = 0;
  - cell 1 is blanked when d2 = 0 and d1 = 0.
- o_cell_active = inside a cell and that cell is not blanked.
- Outside all cells: o_cell_active = 0, o_num = 0, o_gx = 0, o_gy = 0.

Output stage (pipeline stage 2):
- o_draw <= o_cell_active & i_glyph_px, registered.

Reset:
- FSM returns to IDLE; accumulator, counter, d2/d1/d0 = 0.
- All outputs = 0; after reset the readout shows "0" (cell 2 only when BLANK_LZ = 1).
- Reset during CONV aborts the conversion; display registers are forced to 0.

## Timing

- i_frame_stb at cycle 0 gives CONV on cycles 1..8, COMMIT on cycle 9, and new digits visible from cycle 10.
- o_busy is high on cycles 1..9.
- Pixel path:
  - i_x/i_y at cycle n appear as o_num/o_gx/o_gy/o_cell_active at n+1;
  - o_draw for that pixel appears at n+2.
- Fixed 2-clk latency with no stalls; the caller compensates the horizontal offset.
- Simultaneous COMMIT and a pixel lookup: stage 1 on the same clk uses the old digits; the new digits apply from the next clk.
- Value 255 is the maximum: BCD 2/5/5, no overflow possible in 12 bits.

## Test plan

- Reset → all outputs 0, o_busy = 0. Then probe pixel (ORIGIN_X+2·CELL_W, ORIGIN_Y) → o_num = 0 and o_cell_active = 1 one clk later.
- i_value = 123, i_frame_stb pulse → o_busy high for 9 clks, then d2/d1/d0 = 1/2/3. Pixel (ORIGIN_X+CELL_W+3, ORIGIN_Y+5) → o_num = 2, o_gx = 3, o_gy = 5, o_cell_active = 1. With i_glyph_px = 1, o_draw = 1 two clks after the pixel.
- i_value = 7 with BLANK_LZ = 1 → cells 0 and 1 give o_cell_active = 0 and o_draw = 0 even with i_glyph_px = 1. Cell 2 gives o_num = 7.
- i_value = 255, strobe, then change i_value to 9 without a strobe → display stays 2/5/5. A second strobe on cycle 4 of CONV is ignored (digits 2/5/5).
- Boundaries:
  - x = ORIGIN_X − 1, x = ORIGIN_X + 3·CELL_W, y = ORIGIN_Y + CELL_H → o_cell_active = 0.
  - x = ORIGIN_X + 3·CELL_W − 1, y = ORIGIN_Y + CELL_H − 1 → o_cell_active = 1, o_gx = CELL_W − 1, o_gy = CELL_H − 1.
- Reset asserted on cycle 5 of CONV → next clk: IDLE, o_busy = 0, digits 0/0/0.

Source files
------------

// File: rtl/score_digit_ctrl.sv
// ============================================================================
// Module      : score_digit_ctrl
// Description : Sequences one glyph renderer across a 3-digit decimal readout;
//               per-frame double-dabble BCD conversion and 2-stage pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_digit_ctrl #(
    parameter logic [9:0] ORIGIN_X = 10'd280,
    parameter logic [8:0] ORIGIN_Y = 9'd220,
    parameter int         CELL_W   = 16,
    parameter int         CELL_H   = 24,
    parameter int         BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_value,
    input  logic       i_frame_stb,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_glyph_px,
    output logic [3:0] o_num,
    output logic [9:0] o_gx,
    output logic [8:0] o_gy,
    output logic       o_cell_active,
    output logic       o_draw,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [10:0] c_XB0 = 11'(ORIGIN_X);
    localparam logic [10:0] c_XB1 = 11'(int'(ORIGIN_X) + CELL_W);
    localparam logic [10:0] c_XB2 = 11'(int'(ORIGIN_X) + 2 * CELL_W);
    localparam logic [10:0] c_XB3 = 11'(int'(ORIGIN_X) + 3 * CELL_W);
    localparam logic [9:0]  c_YB0 = 10'(ORIGIN_Y);
    localparam logic [9:0]  c_YB1 = 10'(int'(ORIGIN_Y) + CELL_H);
    localparam logic [9:0]  c_GX1 = 10'(int'(ORIGIN_X) + CELL_W);
    localparam logic [9:0]  c_GX2 = 10'(int'(ORIGIN_X) + 2 * CELL_W);

    state_t      r_state;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic [3:0]  r_d2, r_d1, r_d0;
    logic [3:0]  r_num;
    logic [9:0]  r_gx;
    logic [8:0]  r_gy;
    logic        r_act;
    logic        r_draw;

    // Hundreds never exceeds 2 for an 8-bit input, so three bits suffice there.
    logic [2:0]  w_adj_h;
    logic [3:0]  w_adj_t, w_adj_o;
    assign w_adj_h = (r_bcd[10:8] >= 3'd5) ? r_bcd[10:8] + 3'd3 : r_bcd[10:8];
    assign w_adj_t = (r_bcd[7:4]  >= 4'd5) ? r_bcd[7:4]  + 4'd3 : r_bcd[7:4];
    assign w_adj_o = (r_bcd[3:0]  >= 4'd5) ? r_bcd[3:0]  + 4'd3 : r_bcd[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_d2    <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_frame_stb) begin
                        r_bin   <= i_value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= {w_adj_h, w_adj_t, w_adj_o, r_bin, 1'b0};
                    r_cnt          <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_d2    <= r_bcd[11:8];
                    r_d1    <= r_bcd[7:4];
                    r_d0    <= r_bcd[3:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [10:0] w_x;
    logic [9:0]  w_y;
    logic        w_in_y, w_c0, w_c1, w_c2;
    logic        w_blank0, w_blank1;
    logic [8:0]  w_gy;

    assign w_x      = {1'b0, i_x};
    assign w_y      = {1'b0, i_y};
    assign w_in_y   = (w_y >= c_YB0) && (w_y < c_YB1);
    assign w_c0     = w_in_y && (w_x >= c_XB0) && (w_x < c_XB1);
    assign w_c1     = w_in_y && (w_x >= c_XB1) && (w_x < c_XB2);
    assign w_c2     = w_in_y && (w_x >= c_XB2) && (w_x < c_XB3);
    assign w_blank0 = (BLANK_LZ != 0) && (r_d2 == 4'd0);
    assign w_blank1 = w_blank0 && (r_d1 == 4'd0);
    assign w_gy     = i_y - ORIGIN_Y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num  <= '0;
            r_gx   <= '0;
            r_gy   <= '0;
            r_act  <= 1'b0;
            r_draw <= 1'b0;
        end else begin
            r_num  <= '0;
            r_gx   <= '0;
            r_gy   <= '0;
            r_act  <= 1'b0;
            r_draw <= r_act & i_glyph_px;
            if (w_c0) begin
                r_num <= r_d2;
                r_gx  <= i_x - ORIGIN_X;
                r_gy  <= w_gy;
                r_act <= !w_blank0;
            end else if (w_c1) begin
                r_num <= r_d1;
                r_gx  <= i_x - c_GX1;
                r_gy  <= w_gy;
                r_act <= !w_blank1;
            end else if (w_c2) begin
                r_num <= r_d0;
                r_gx  <= i_x - c_GX2;
                r_gy  <= w_gy;
                r_act <= 1'b1;
            end
        end
    end

    assign o_num         = r_num;
    assign o_gx          = r_gx;
    assign o_gy          = r_gy;
    assign o_cell_active = r_act;
    assign o_draw        = r_draw;
    assign o_busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_score_digit_ctrl.sv
// ============================================================================
// Module      : tb_score_digit_ctrl
// Description : Scoreboard bench for score_digit_ctrl (conversion and pixel path).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_digit_ctrl;

    localparam int OX = 280;
    localparam int OY = 220;
    localparam int CW = 16;
    localparam int CH = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_value = '0;
    logic       i_frame_stb = 1'b0;
    logic [9:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic       i_glyph_px = 1'b0;
    logic [3:0] o_num;
    logic [9:0] o_gx;
    logic [8:0] o_gy;
    logic       o_cell_active, o_draw, o_busy;

    typedef struct {
        logic [3:0] num;
        logic [9:0] gx;
        logic [8:0] gy;
        logic       act;
        logic       draw;
    } exp_t;

    exp_t sbq[$];
    int   m_d[3];
    int   n_vec = 0;
    int   n_err = 0;

    score_digit_ctrl #(
        .ORIGIN_X(10'(OX)), .ORIGIN_Y(9'(OY)), .CELL_W(CW), .CELL_H(CH), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .reset(reset), .i_value(i_value), .i_frame_stb(i_frame_stb),
        .i_x(i_x), .i_y(i_y), .i_glyph_px(i_glyph_px),
        .o_num(o_num), .o_gx(o_gx), .o_gy(o_gy), .o_cell_active(o_cell_active),
        .o_draw(o_draw), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic void set_model(int v);
        m_d[0] = v / 100;
        m_d[1] = (v / 10) % 10;
        m_d[2] = v % 10;
    endfunction

    // Drives one pixel, queues its expected result, and returns at the stage-1 sample point.
    task automatic probe(int x, int y, bit g);
        exp_t e;
        int   dx, dy, k;
        bit   blank;
        @(negedge clk);
        i_x = 10'(x); i_y = 9'(y); i_glyph_px = g;
        e = '{num: 4'd0, gx: 10'd0, gy: 9'd0, act: 1'b0, draw: 1'b0};
        dx = x - OX; dy = y - OY;
        if (dy >= 0 && dy < CH && dx >= 0 && dx < 3 * CW) begin
            k     = dx / CW;
            blank = (k == 0 && m_d[0] == 0) || (k == 1 && m_d[0] == 0 && m_d[1] == 0);
            e.num = 4'(m_d[k]);
            e.gx  = 10'(dx - k * CW);
            e.gy  = 9'(dy);
            e.act = !blank;
            e.draw = !blank && g;
        end
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_strobe(int v);
        @(negedge clk);
        i_value = 8'(v); i_frame_stb = 1'b1;
        @(negedge clk);
        i_frame_stb = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({o_num, o_gx, o_gy, o_cell_active, o_draw, o_busy} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h required 0",
                     {o_num, o_gx, o_gy, o_cell_active, o_draw, o_busy});
        end
        @(negedge clk) reset = 1'b0;
        set_model(0);
        probe(OX + 2 * CW, OY, 1'b1);
        e = sbq.pop_front();
        n_vec++;
        if (o_num !== e.num || o_cell_active !== e.act || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_probe got num=%0d act=%b busy=%b required num=%0d act=%b busy=0",
                     o_num, o_cell_active, o_busy, e.num, e.act);
        end
    endtask

    task automatic test_convert_123;
        exp_t e;
        int   cnt;
        do_strobe(123);
        cnt = 0;
        for (int i = 0; i < 20 && o_busy; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (cnt != 9) begin
            n_err++;
            $display("FAIL busy_len_123 got %0d required 9", cnt);
        end
        set_model(123);
        for (int p = 0; p < 3; p++) begin
            probe(OX + p * CW + 3, OY + 5, 1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({o_num, o_gx, o_gy, o_cell_active} !== {e.num, e.gx, e.gy, e.act}) begin
                n_err++;
                $display("FAIL pix123_c%0d got num=%0d gx=%0d gy=%0d act=%b required num=%0d gx=%0d gy=%0d act=%b",
                         p, o_num, o_gx, o_gy, o_cell_active, e.num, e.gx, e.gy, e.act);
            end
            @(posedge clk); #1;
            n_vec++;
            if (o_draw !== e.draw) begin
                n_err++;
                $display("FAIL draw123_c%0d got %b required %b", p, o_draw, e.draw);
            end
        end
    endtask

    task automatic test_blanking;
        exp_t e;
        do_strobe(7);
        for (int i = 0; i < 20 && o_busy; i++) begin
            @(posedge clk); #1;
        end
        set_model(7);
        for (int p = 0; p < 3; p++) begin
            probe(OX + p * CW + 4, OY + 7, 1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({o_num, o_cell_active} !== {e.num, e.act}) begin
                n_err++;
                $display("FAIL blank7_c%0d got num=%0d act=%b required num=%0d act=%b",
                         p, o_num, o_cell_active, e.num, e.act);
            end
            @(posedge clk); #1;
            n_vec++;
            if (o_draw !== e.draw) begin
                n_err++;
                $display("FAIL blank7_draw_c%0d got %b required %b", p, o_draw, e.draw);
            end
        end
    endtask

    task automatic test_hold_and_ignore;
        exp_t e;
        int   cnt;
        do_strobe(255);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        i_value = 8'd9; i_frame_stb = 1'b1;
        @(negedge clk);
        i_frame_stb = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && o_busy; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (cnt != 5) begin
            n_err++;
            $display("FAIL busy_tail_255 got %0d required 5", cnt);
        end
        repeat (12) @(posedge clk);
        #1;
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_stb_busy got %b required 0", o_busy);
        end
        set_model(255);
        for (int p = 0; p < 3; p++) begin
            probe(OX + p * CW + 1, OY + 2, 1'b0);
            e = sbq.pop_front();
            n_vec++;
            if ({o_num, o_cell_active} !== {e.num, e.act}) begin
                n_err++;
                $display("FAIL hold255_c%0d got num=%0d act=%b required num=%0d act=%b",
                         p, o_num, o_cell_active, e.num, e.act);
            end
        end
    endtask

    task automatic test_bounds;
        exp_t e;
        int   bx[7] = '{OX - 1, OX + 3 * CW, OX, OX + 3 * CW - 1, OX, OX + CW - 1, OX + CW};
        int   by[7] = '{OY, OY, OY + CH, OY + CH - 1, OY - 1, OY, OY + CH - 1};
        for (int p = 0; p < 7; p++) begin
            probe(bx[p], by[p], 1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({o_num, o_gx, o_gy, o_cell_active} !== {e.num, e.gx, e.gy, e.act}) begin
                n_err++;
                $display("FAIL bound%0d x=%0d y=%0d got num=%0d gx=%0d gy=%0d act=%b required num=%0d gx=%0d gy=%0d act=%b",
                         p, bx[p], by[p], o_num, o_gx, o_gy, o_cell_active, e.num, e.gx, e.gy, e.act);
            end
            @(posedge clk); #1;
            n_vec++;
            if (o_draw !== e.draw) begin
                n_err++;
                $display("FAIL bound%0d_draw got %b required %b", p, o_draw, e.draw);
            end
        end
    endtask

    task automatic test_reset_mid_conv;
        exp_t e;
        do_strobe(77);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({o_num, o_gx, o_gy, o_cell_active, o_draw, o_busy} !== 26'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got %h required 0",
                     {o_num, o_gx, o_gy, o_cell_active, o_draw, o_busy});
        end
        @(negedge clk) reset = 1'b0;
        set_model(0);
        for (int p = 0; p < 3; p++) begin
            probe(OX + p * CW + 2, OY + 3, 1'b1);
            e = sbq.pop_front();
            n_vec++;
            if ({o_num, o_cell_active, o_busy} !== {e.num, e.act, 1'b0}) begin
                n_err++;
                $display("FAIL midreset_c%0d got num=%0d act=%b busy=%b required num=%0d act=%b busy=0",
                         p, o_num, o_cell_active, o_busy, e.num, e.act);
            end
        end
    endtask

    initial begin
        test_reset;
        test_convert_123;
        test_blanking;
        test_hold_and_ignore;
        test_bounds;
        test_reset_mid_conv;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
